mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle control unit for the ARM subset (ADD/SUB/AND/ORR, LDR/STR, B). Sequences a shared-ALU,
//  single-memory datapath over 3-5 states per instruction and waits on a memory-ready handshake.
//  Owns the NZCV flag register and condition check. Datapath holds IR, A/WriteData/ALUOut/Data regs.
// PARAMETERS
//  RST_STATE  4'd0  state entered on reset (FETCH); not intended to be overridden
// PORTS
//  clk         in   1   clock, all state changes on rising edge
//  reset       in   1   asynchronous, active-high
//  Instr       in   20  IR[31:12]: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//  ALUFlags    in   4   {N,Z,C,V} from ALU, current cycle
//  mem_ready   in   1   memory completed the access presented this cycle
//  PCWrite     out  1   load PC from Result
//  AdrSrc      out  1   memory address: 0=PC, 1=ALUOut
//  MemWrite    out  1   memory write strobe
//  IRWrite     out  1   load IR from memory read data
//  ResultSrc   out  2   00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA     out  1   0=A reg (Rn), 1=PC
//  ALUSrcB     out  2   00=WriteData reg, 01=ExtImm, 10=const 4
//  ALUControl  out  2   00 add, 01 sub, 10 and, 11 or
//  ImmSrc      out  2   00 imm8, 01 imm12, 10 branch imm24<<2
//  RegSrc      out  2   [0]: RA1=R15; [1]: RA2=Rd
//  RegWrite    out  1   register-file write
//  illegal     out  1   one-cycle pulse in DECODE on unsupported encoding
//  state       out  4   current state, debug
// BEHAVIOUR
//  - Reset: state=FETCH, Flags=0000; all strobes (PCWrite,MemWrite,IRWrite,RegWrite,illegal)=0 while reset high.
//  - Moore outputs per state; unspecified selects=0. Strobes below are the only writes.
//  - FETCH(0): AdrSrc0 ALUSrcA1 ALUSrcB10 add ResultSrc10; IRWrite=PCWrite=mem_ready; stay until mem_ready, then DECODE.
//  - DECODE(1): ALUSrcA1 ALUSrcB10 add (PC+8 path); RegSrc={Op==01, Op==10}. CondEx from Cond vs latched Flags
//    (EQ..LE, AL; 1111 -> false). CondEx=0 -> FETCH, no writes. Op00,F5=0 -> EXECR; Op00,F5=1 -> EXECI;
//    Op01 -> MEMADR; Op10 -> BRANCH. Op11, or Op00 with Funct[4:1] not in {0100,0010,0000,1100}:
//    illegal=1, -> FETCH, no architectural effect.
//  - EXECR(6): ALUSrcA0 ALUSrcB00; EXECI(7): ALUSrcA0 ALUSrcB01 ImmSrc00. ALUControl: Funct[4:1]
//    0100 add, 0010 sub, 0000 and, 1100 or. If Funct[0]: latch NZ at clock edge; CV too only for add/sub. -> ALUWB.
//  - ALUWB(8): ResultSrc00 RegWrite1; PCWrite1 iff Rd==1111. -> FETCH.
//  - MEMADR(2): ALUSrcA0 ALUSrcB01 ImmSrc01 add. Funct[0]=1 -> MEMRD else MEMWR.
//  - MEMRD(3): AdrSrc1; hold until mem_ready, then MEMWB. MEMWB(4): ResultSrc01 RegWrite1; PCWrite1 iff Rd==1111. -> FETCH.
//  - MEMWR(5): AdrSrc1 MemWrite1, held every cycle until mem_ready; then FETCH.
//  - BRANCH(9): ALUSrcA0 (R15=PC+8) ALUSrcB01 ImmSrc10 add ResultSrc10 PCWrite1. -> FETCH.
//  - Flags change only in EXECR/EXECI with S=1; never on loads/stores/branches/skipped instrs.
//  - Cycle counts (mem_ready=1): branch 3, ALU 4, STR 4, LDR 5; each mem_ready=0 cycle adds one.
//  - Unused encodings 10-15 -> FETCH next cycle, strobes 0.
//  - Reset mid-instruction (incl. MEMWR wait): strobes drop immediately, FETCH on release, Flags cleared.
// TESTING
//  - Reset, mem_ready=1, ADD R1,R0,#5 (E2801005) -> states 0,1,7,8,0; RegWrite only in ALUWB; ALUControl=00.
//  - SUBS R2,R1,R1 (E0512001) -> Flags Z=1,C=1 after EXECR; following ADDEQ executes, ADDNE skips at DECODE.
//  - LDR with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, RegWrite once in MEMWB, 8 cycles total.
//  - STR: MemWrite=1 and AdrSrc=1 continuously through stall, exactly one cycle with MemWrite&mem_ready.
//  - B (EA000001) -> states 0,1,9; PCWrite in FETCH and BRANCH; ImmSrc=10; Flags unchanged.
//  - Op=11 or Funct[4:1]=0001 -> illegal pulse 1 cycle, back to FETCH, no RegWrite/MemWrite; reset asserted in MEMWR -> MemWrite 0 same cycle.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for an ARM subset (data-processing, LDR/STR, B).
// Sequences a shared-ALU, single-memory datapath and owns the NZCV flag register.
module mc_control_fsm #(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags;          // {N,Z,C,V}
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       cond_ex;
    logic       dp_ok;
    logic       supported;
    logic [1:0] alu_ctl;
    logic       pcw, irw, memw, regw, ill;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign cmd       = funct[4:1];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags[2];
            4'b0001: cond_ex = ~flags[2];
            4'b0010: cond_ex = flags[1];
            4'b0011: cond_ex = ~flags[1];
            4'b0100: cond_ex = flags[3];
            4'b0101: cond_ex = ~flags[3];
            4'b0110: cond_ex = flags[0];
            4'b0111: cond_ex = ~flags[0];
            4'b1000: cond_ex = flags[1] & ~flags[2];
            4'b1001: cond_ex = ~flags[1] | flags[2];
            4'b1010: cond_ex = (flags[3] == flags[0]);
            4'b1011: cond_ex = (flags[3] != flags[0]);
            4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctl = 2'b00;
        dp_ok   = 1'b1;
        case (cmd)
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            default: dp_ok   = 1'b0;
        endcase
    end

    assign supported = (op != 2'b11) && !((op == 2'b00) && !dp_ok);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= state_t'(RST_STATE);
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if ((state_q == EXECR || state_q == EXECI) && funct[0]) begin
            flags[3:2] <= ALUFlags[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010) flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d    = FETCH;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        pcw        = 1'b0;
        irw        = 1'b0;
        memw       = 1'b0;
        regw       = 1'b0;
        ill        = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = mem_ready;
                pcw       = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                RegSrc  = {op == 2'b01, op == 2'b10};
                if (!supported) begin
                    ill = 1'b1;
                end else if (cond_ex) begin
                    case (op)
                        2'b00:   state_d = funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            EXECR: begin
                ALUControl = alu_ctl;
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctl;
                state_d    = ALUWB;
            end
            ALUWB: begin
                regw = 1'b1;
                pcw  = (rd == 4'hF);
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
                pcw       = (rd == 4'hF);
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                memw    = 1'b1;
                state_d = mem_ready ? FETCH : MEMWR;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                pcw       = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset so they drop in the same cycle reset rises.
    assign PCWrite  = pcw  & ~reset;
    assign IRWrite  = irw  & ~reset;
    assign MemWrite = memw & ~reset;
    assign RegWrite = regw & ~reset;
    assign illegal  = ill  & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instructions plus random ones,
// compared against an instruction-level model of the ARM-subset control behaviour.
module tb_mc_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9;

    typedef enum {K_ALU, K_LDR, K_STR, K_B, K_ILL, K_SKIP} kind_e;
    typedef struct packed { logic [3:0] st; logic rdy; } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  state;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] mflags   = 4'b0000;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Condition evaluation: odd codes are the negation of the even code below them.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !r : r;
    endfunction

    function automatic bit is_illegal(input logic [31:0] ir);
        logic [3:0] cmd;
        cmd = ir[24:21];
        return (ir[27:26] == 2'b11) ||
               (ir[27:26] == 2'b00 && !(cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12));
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'd2:    return 2'b01;
            4'd0:    return 2'b10;
            4'd12:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Run one instruction; cut>0 stops after that many cycles with no end-of-instruction checks.
    task automatic run_instr(input logic [31:0] ir, input int fst, input int mst,
                             input logic [31:0] a, input logic [31:0] b, input int cut);
        kind_e      k;
        step_t      tr[$];
        logic [3:0] cmd, exf, rd;
        logic [32:0] wide;
        logic [31:0] r;
        logic       c, v, s;
        int         lim;
        int         n_rw = 0, n_pc = 0, n_ir = 0, n_mw = 0, n_mwr = 0, n_ill = 0;
        cmd = ir[24:21];
        s   = ir[20];
        rd  = ir[15:12];
        if (is_illegal(ir))                k = K_ILL;
        else if (!cond_ok(ir[31:28], mflags)) k = K_SKIP;
        else if (ir[27:26] == 2'b00)       k = K_ALU;
        else if (ir[27:26] == 2'b01)       k = s ? K_LDR : K_STR;
        else                               k = K_B;

        c = 1'($urandom);
        v = 1'($urandom);
        r = 32'd0;
        case (cmd)
            4'd4: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0]; c = wide[32]; v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd2: begin
                wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = wide[31:0]; c = wide[32]; v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd0:    r = a & b;
            4'd12:   r = a | b;
            default: r = 32'd0;
        endcase
        exf = {r[31], r == 32'd0, c, v};

        for (int i = 0; i < fst; i++) tr.push_back('{S_FETCH, 1'b0});
        tr.push_back('{S_FETCH, 1'b1});
        tr.push_back('{S_DECODE, 1'($urandom)});
        case (k)
            K_ALU: begin
                tr.push_back('{ir[25] ? S_EXECI : S_EXECR, 1'($urandom)});
                tr.push_back('{S_ALUWB, 1'($urandom)});
            end
            K_LDR: begin
                tr.push_back('{S_MEMADR, 1'($urandom)});
                for (int i = 0; i < mst; i++) tr.push_back('{S_MEMRD, 1'b0});
                tr.push_back('{S_MEMRD, 1'b1});
                tr.push_back('{S_MEMWB, 1'($urandom)});
            end
            K_STR: begin
                tr.push_back('{S_MEMADR, 1'($urandom)});
                for (int i = 0; i < mst; i++) tr.push_back('{S_MEMWR, 1'b0});
                tr.push_back('{S_MEMWR, 1'b1});
            end
            K_B:     tr.push_back('{S_BRANCH, 1'($urandom)});
            default: ;
        endcase

        Instr = ir[31:12];
        lim = (cut != 0) ? cut : tr.size();
        for (int i = 0; i < lim; i++) begin
            mem_ready = tr[i].rdy;
            ALUFlags  = (tr[i].st == S_EXECR || tr[i].st == S_EXECI) ? exf : 4'($urandom);
            @(negedge clk);
            check("state", {28'd0, state}, {28'd0, tr[i].st});
            n_rw  += int'(RegWrite);
            n_pc  += int'(PCWrite);
            n_ir  += int'(IRWrite);
            n_mw  += int'(MemWrite);
            n_mwr += int'(MemWrite & mem_ready);
            n_ill += int'(illegal);
            case (tr[i].st)
                S_FETCH: begin
                    check("fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}, 8'b0_1_10_00_10);
                    check("fetch_strobes", {IRWrite, PCWrite}, {mem_ready, mem_ready});
                end
                S_DECODE: begin
                    check("decode_sel", {ALUSrcA, ALUSrcB, ALUControl, RegSrc},
                          {1'b1, 2'b10, 2'b00, ir[27:26] == 2'b01, ir[27:26] == 2'b10});
                    check("decode_illegal", illegal, k == K_ILL);
                end
                S_EXECR, S_EXECI:
                    check("exec_sel", {ALUSrcA, ALUSrcB, ImmSrc, ALUControl},
                          {1'b0, ir[25] ? 2'b01 : 2'b00, 2'b00, alu_code(cmd)});
                S_ALUWB:  check("aluwb", {ResultSrc, RegWrite, PCWrite}, {2'b00, 1'b1, rd == 4'hF});
                S_MEMWB:  check("memwb", {ResultSrc, RegWrite, PCWrite}, {2'b01, 1'b1, rd == 4'hF});
                S_MEMADR: check("memadr_sel", {ALUSrcA, ALUSrcB, ImmSrc, ALUControl}, 7'b0_01_01_00);
                S_MEMRD:  check("memrd", {AdrSrc, MemWrite}, 2'b10);
                S_MEMWR:  check("memwr", {AdrSrc, MemWrite}, 2'b11);
                S_BRANCH: check("branch_sel", {ALUSrcA, ALUSrcB, ImmSrc, ALUControl, ResultSrc, PCWrite},
                                10'b0_01_10_00_10_1);
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        if (cut != 0) return;

        check("n_regwrite", n_rw, (k == K_ALU || k == K_LDR) ? 1 : 0);
        check("n_pcwrite", n_pc, 1 + ((k == K_B) ? 1 : 0) +
                                 (((k == K_ALU || k == K_LDR) && rd == 4'hF) ? 1 : 0));
        check("n_irwrite", n_ir, 1);
        check("n_memwrite", n_mw, (k == K_STR) ? mst + 1 : 0);
        check("n_memwrite_ready", n_mwr, (k == K_STR) ? 1 : 0);
        check("n_illegal", n_ill, (k == K_ILL) ? 1 : 0);
        if (k == K_ALU && s) begin
            mflags[3:2] = exf[3:2];
            if (cmd == 4'd4 || cmd == 4'd2) mflags[1:0] = exf[1:0];
        end
        check("flags", dut.flags, mflags);
    endtask

    initial begin
        logic [31:0] ir, a, b;
        logic [5:0]  funct;
        logic [3:0]  cmds [4];
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12};

        reset     = 1'b1;
        mem_ready = 1'b1;
        Instr     = 20'd0;
        ALUFlags  = 4'b1111;
        @(negedge clk);
        check("reset_state", state, S_FETCH);
        check("reset_strobes", {PCWrite, MemWrite, IRWrite, RegWrite, illegal}, 5'b0);
        check("reset_flags", dut.flags, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(32'hE2801005, 0, 0, 32'd0, 32'd5, 0);            // ADD R1,R0,#5
        run_instr(32'hE0512001, 0, 0, 32'h1234, 32'h1234, 0);      // SUBS R2,R1,R1
        check("subs_zc", dut.flags[2:1], 2'b11);
        run_instr(32'h02802001, 0, 0, 32'd3, 32'd1, 0);            // ADDEQ executes
        run_instr(32'h12802001, 0, 0, 32'd3, 32'd1, 0);            // ADDNE skipped
        run_instr(32'hE5901000, 0, 3, 32'd0, 32'd0, 0);            // LDR with 3 stall cycles
        run_instr(32'hE5801000, 0, 2, 32'd0, 32'd0, 0);            // STR with 2 stall cycles
        run_instr(32'hEA000001, 0, 0, 32'd0, 32'd0, 0);            // B
        run_instr(32'hE0201000, 0, 0, 32'd0, 32'd0, 0);            // EOR: unsupported
        run_instr(32'hEC000000, 0, 0, 32'd0, 32'd0, 0);            // Op=11
        run_instr(32'hE280F004, 0, 0, 32'd8, 32'd4, 0);            // ADD PC,R0,#4
        run_instr(32'hE0912003, 2, 0, 32'hFFFF_FFFF, 32'd1, 0);    // ADDS with fetch stall
        run_instr(32'hE1903002, 0, 0, 32'h8000_0000, 32'd0, 0);    // ORRS: N only, CV kept

        // Reset asserted while a store waits in MEMWR.
        run_instr(32'hE5801000, 0, 5, 32'd0, 32'd0, 4);
        mem_ready = 1'b0;
        #1 check("memwr_before_reset", MemWrite, 1'b1);
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("memwr_reset_memwrite", {MemWrite, IRWrite, PCWrite}, 3'b000);
        check("memwr_reset_state", state, S_FETCH);
        check("memwr_reset_flags", dut.flags, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;
        mflags = 4'b0000;
        run_instr(32'h02802001, 0, 0, 32'd0, 32'd0, 0);            // ADDEQ now skipped

        for (int n = 0; n < 60; n++) begin
            funct = 6'($urandom);
            ir = {4'($urandom), 2'($urandom), funct, 20'($urandom)};
            if (ir[27:26] == 2'b00 && $urandom_range(0, 3) != 0) ir[24:21] = cmds[$urandom_range(0, 3)];
            if (is_illegal(ir)) ir[31:28] = 4'hE;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 3), a, b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
